boot_bus_master: RTL and testbench

- Bus translation unit directly downstream of the control unit's boot-control request port.
- Converts one `bootControl_bus_go` request (128-bit payload, read or write) into a single AHB-Lite INCR4 burst of 32-bit beats.
- Returns assembled read data and a one-cycle `bootControl_bus_done` pulse.
- Sole AHB master for secure-boot and firmware-authentication traffic.

---
 rtl/boot_bus_pkg.sv | 33 +++
 rtl/boot_bus_master_if.sv | 29 ++
 rtl/boot_bus_master.sv | 174 +++++++++++++++++
 tb/tb_boot_bus_master.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_bus_pkg.sv
// boot_bus_pkg
// Shared types and constants for the boot-control AHB-Lite master:
//   - state_e  : transaction FSM states
//   - htrans_e : AHB HTRANS encodings
//   - HBURST/HSIZE/HRESP constants
//   - beats()  : number of bus beats per request payload
package boot_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_BURST,
        ST_LAST,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HBURST_INCR4 = 3'b011;
    localparam logic [2:0] HSIZE_WORD   = 3'b010;
    localparam logic       HRESP_OKAY   = 1'b0;
    localparam logic       HRESP_ERROR  = 1'b1;

    function automatic int beats(int payload_bits, int data_bits);
        return payload_bits / data_bits;
    endfunction

endpackage

// File: rtl/boot_bus_master_if.sv
// boot_bus_master_if
// AHB-Lite master/slave signal bundle.
//   master modport: drives HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA,
//                   samples HRDATA/HREADY/HRESP
//   slave  modport: the reverse
interface boot_bus_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;
    logic          HRESP;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/boot_bus_master.sv
// boot_bus_master
// Turns one boot-control request (128-bit payload, read or write) into a
// single AHB-Lite INCR4 burst of 32-bit beats, then pulses done for one
// cycle with the assembled read payload and an error flag.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   bootControl_bus_go       request strobe (only looked at in IDLE)
//   bootControl_bus_addr     byte base address, low 4 bits ignored
//   bootControl_bus_write    write payload, beat i = bits [32i+31:32i]
//   bootControl_bus_RW       1 = write, 0 = read
//   bootControl_bus_done     one-cycle completion pulse
//   bootControl_bus_rdData   assembled read payload (held until next go)
//   bootControl_bus_err      an ERROR response was seen (held until next go)
//   ahb                      AHB-Lite master port
module boot_bus_master
    import boot_bus_pkg::*;
#(
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pAHB_DATA_WIDTH    = 32,
    parameter int pPAYLOAD_SIZE_BITS = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bootControl_bus_go,
    input  logic [pAHB_ADDR_WIDTH-1:0]    bootControl_bus_addr,
    input  logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_write,
    input  logic                          bootControl_bus_RW,
    output logic                          bootControl_bus_done,
    output logic [pPAYLOAD_SIZE_BITS-1:0] bootControl_bus_rdData,
    output logic                          bootControl_bus_err,
    boot_bus_master_if.master             ahb
);

    localparam int AW    = pAHB_ADDR_WIDTH;
    localparam int DW    = pAHB_DATA_WIDTH;
    localparam int BEATS = beats(pPAYLOAD_SIZE_BITS, pAHB_DATA_WIDTH);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e                   state_q;
    logic [AW-1:0]            base_q;
    logic [AW-1:0]            haddr_q;
    htrans_e                  htrans_q;
    logic                     hwrite_q;
    logic [2:0]               hsize_q;
    logic [2:0]               hburst_q;
    logic [DW-1:0]            hwdata_q;
    logic [BEATS-1:0][DW-1:0] wdata_q;
    logic [BEATS-1:0][DW-1:0] rdata_q;
    // abeat_q: beat whose address phase is on the bus
    // dbeat_q: beat whose data phase is on the bus
    logic [BW-1:0]            abeat_q;
    logic [BW-1:0]            dbeat_q;
    logic                     rw_q;
    logic                     done_q;
    logic                     err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hwdata_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            abeat_q  <= '0;
            dbeat_q  <= '0;
            rw_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bootControl_bus_go) begin
                        // 16-byte alignment keeps the burst inside one 1 KB page
                        base_q   <= bootControl_bus_addr & ~AW'(15);
                        haddr_q  <= bootControl_bus_addr & ~AW'(15);
                        htrans_q <= HTRANS_NONSEQ;
                        hwrite_q <= bootControl_bus_RW;
                        hsize_q  <= HSIZE_WORD;
                        hburst_q <= HBURST_INCR4;
                        rw_q     <= bootControl_bus_RW;
                        wdata_q  <= bootControl_bus_write;
                        rdata_q  <= '0;
                        err_q    <= 1'b0;
                        abeat_q  <= '0;
                        dbeat_q  <= '0;
                        state_q  <= ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    // No data phase is in flight yet, so only HREADY matters
                    if (ahb.HREADY) begin
                        abeat_q  <= BW'(1);
                        dbeat_q  <= '0;
                        haddr_q  <= base_q + AW'(4);
                        htrans_q <= HTRANS_SEQ;
                        hwdata_q <= wdata_q[0];
                        state_q  <= ST_BURST;
                    end
                end

                ST_BURST: begin
                    if (ahb.HRESP == HRESP_ERROR) begin
                        if (ahb.HREADY) begin
                            err_q    <= 1'b1;
                            done_q   <= 1'b1;
                            htrans_q <= HTRANS_IDLE;
                            hwrite_q <= 1'b0;
                            hsize_q  <= '0;
                            hburst_q <= '0;
                            hwdata_q <= '0;
                            state_q  <= ST_DONE;
                        end else begin
                            // First cycle of ERROR: cancel the pending beat,
                            // then wait out the second cycle in LAST
                            htrans_q <= HTRANS_IDLE;
                            state_q  <= ST_LAST;
                        end
                    end else if (ahb.HREADY) begin
                        if (!rw_q) rdata_q[dbeat_q] <= ahb.HRDATA;
                        dbeat_q  <= abeat_q;
                        hwdata_q <= wdata_q[abeat_q];
                        if (abeat_q == BW'(BEATS - 1)) begin
                            htrans_q <= HTRANS_IDLE;
                            state_q  <= ST_LAST;
                        end else begin
                            abeat_q <= abeat_q + 1'b1;
                            haddr_q <= base_q + (AW'(abeat_q + 1'b1) << 2);
                        end
                    end
                end

                ST_LAST: begin
                    if (ahb.HREADY) begin
                        if (ahb.HRESP == HRESP_ERROR) err_q <= 1'b1;
                        else if (!rw_q) rdata_q[dbeat_q] <= ahb.HRDATA;
                        done_q   <= 1'b1;
                        hwrite_q <= 1'b0;
                        hsize_q  <= '0;
                        hburst_q <= '0;
                        hwdata_q <= '0;
                        state_q  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // go is deliberately not sampled here
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ahb.HADDR  = haddr_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = hwrite_q;
    assign ahb.HSIZE  = hsize_q;
    assign ahb.HBURST = hburst_q;
    assign ahb.HWDATA = hwdata_q;

    assign bootControl_bus_done   = done_q;
    assign bootControl_bus_rdData = rdata_q;
    assign bootControl_bus_err    = err_q;

endmodule

// File: tb/tb_boot_bus_master.sv
// tb_boot_bus_master
// Directed bench for boot_bus_master: write burst, read with wait states,
// read with ERROR, ignored go pulses, mid-burst reset, back-to-back bursts.
module tb_boot_bus_master;
    import boot_bus_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         go;
    logic [31:0]  addr;
    logic [127:0] wr;
    logic         rw;
    logic         done;
    logic [127:0] rd;
    logic         err;

    int total = 0;
    int bad   = 0;
    int dc;

    localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] W2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    always #5 clk = ~clk;

    boot_bus_master_if #(.AW(32), .DW(32)) ahb ();

    boot_bus_master #(
        .pAHB_ADDR_WIDTH(32),
        .pAHB_DATA_WIDTH(32),
        .pPAYLOAD_SIZE_BITS(128)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bootControl_bus_go(go),
        .bootControl_bus_addr(addr),
        .bootControl_bus_write(wr),
        .bootControl_bus_RW(rw),
        .bootControl_bus_done(done),
        .bootControl_bus_rdData(rd),
        .bootControl_bus_err(err),
        .ahb(ahb.master)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; go = 1'b0; addr = '0; wr = '0; rw = 1'b0;
        ahb.HREADY = 1'b1; ahb.HRDATA = '0; ahb.HRESP = 1'b0;
        #12;
        chk("rst_htrans", ahb.HTRANS, 2'b00);
        chk("rst_haddr",  ahb.HADDR, 32'h0);
        chk("rst_hsize",  ahb.HSIZE, 3'b000);
        chk("rst_done",   done, 1'b0);
        chk("rst_rddata", rd, 128'h0);
        chk("rst_err",    err, 1'b0);
        rst_n = 1'b1;
        step();

        // ---- write, zero wait ----
        go = 1'b1; rw = 1'b1; addr = 32'h1000_0008; wr = W1;
        step(); // cycle 1
        go = 1'b0;
        chk("w_c1_htrans", ahb.HTRANS, 2'b10);
        chk("w_c1_haddr",  ahb.HADDR, 32'h1000_0000);
        chk("w_c1_hwrite", ahb.HWRITE, 1'b1);
        chk("w_c1_hsize",  ahb.HSIZE, 3'b010);
        chk("w_c1_hburst", ahb.HBURST, 3'b011);
        step(); // cycle 2
        chk("w_c2_htrans", ahb.HTRANS, 2'b11);
        chk("w_c2_haddr",  ahb.HADDR, 32'h1000_0004);
        chk("w_c2_hwdata", ahb.HWDATA, 32'h1111_1111);
        step(); // cycle 3
        chk("w_c3_haddr",  ahb.HADDR, 32'h1000_0008);
        chk("w_c3_hwdata", ahb.HWDATA, 32'h2222_2222);
        step(); // cycle 4
        chk("w_c4_htrans", ahb.HTRANS, 2'b11);
        chk("w_c4_haddr",  ahb.HADDR, 32'h1000_000C);
        chk("w_c4_hwdata", ahb.HWDATA, 32'h3333_3333);
        step(); // cycle 5
        chk("w_c5_htrans", ahb.HTRANS, 2'b00);
        chk("w_c5_hwdata", ahb.HWDATA, 32'h4444_4444);
        chk("w_c5_done",   done, 1'b0);
        step(); // cycle 6
        chk("w_c6_done", done, 1'b1);
        chk("w_c6_err",  err, 1'b0);
        step(); // cycle 7
        chk("w_c7_done", done, 1'b0);

        // ---- read, 2 wait states on beat 1 ----
        go = 1'b1; rw = 1'b0; addr = 32'h2000_0010;
        step(); // cycle 1
        go = 1'b0;
        chk("r_c1_htrans", ahb.HTRANS, 2'b10);
        chk("r_c1_haddr",  ahb.HADDR, 32'h2000_0010);
        chk("r_c1_hwrite", ahb.HWRITE, 1'b0);
        step(); // cycle 2: beat 0 data
        ahb.HRDATA = 32'h0000_00A0; ahb.HREADY = 1'b1;
        step(); // cycle 3: beat 1 data, stalled
        chk("r_c3_haddr", ahb.HADDR, 32'h2000_0018);
        ahb.HREADY = 1'b0; ahb.HRDATA = 32'hDEAD_BEEF;
        step(); // cycle 4
        chk("r_c4_hold_haddr",  ahb.HADDR, 32'h2000_0018);
        chk("r_c4_hold_htrans", ahb.HTRANS, 2'b11);
        step(); // cycle 5
        chk("r_c5_hold_haddr",  ahb.HADDR, 32'h2000_0018);
        ahb.HREADY = 1'b1; ahb.HRDATA = 32'h0000_00A1;
        step(); // cycle 6
        chk("r_c6_haddr", ahb.HADDR, 32'h2000_001C);
        ahb.HRDATA = 32'h0000_00A2;
        step(); // cycle 7
        chk("r_c7_htrans", ahb.HTRANS, 2'b00);
        chk("r_c7_done",   done, 1'b0);
        ahb.HRDATA = 32'h0000_00A3;
        step(); // cycle 8
        chk("r_c8_done",   done, 1'b1);
        chk("r_c8_rddata", rd, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("r_c8_err",    err, 1'b0);
        step();

        // ---- read with ERROR on beat 2 ----
        go = 1'b1; rw = 1'b0; addr = 32'h3000_0000;
        step(); // cycle 1
        go = 1'b0;
        step(); // cycle 2
        ahb.HRDATA = 32'h0000_00B0;
        step(); // cycle 3
        ahb.HRDATA = 32'h0000_00B1;
        step(); // cycle 4: beat 2 data, first ERROR cycle
        chk("e_c4_htrans", ahb.HTRANS, 2'b11);
        ahb.HRDATA = 32'h0000_00B2; ahb.HRESP = 1'b1; ahb.HREADY = 1'b0;
        step(); // cycle 5
        chk("e_c5_htrans", ahb.HTRANS, 2'b00);
        ahb.HREADY = 1'b1;
        step(); // cycle 6
        chk("e_c6_done",   done, 1'b1);
        chk("e_c6_err",    err, 1'b1);
        chk("e_c6_rddata", rd, 128'h00000000_00000000_000000B1_000000B0);
        ahb.HRESP = 1'b0;
        step();
        chk("e_hold_err",  err, 1'b1);
        chk("e_hold_done", done, 1'b0);

        // ---- go pulses during an active burst are ignored ----
        go = 1'b1; rw = 1'b1; addr = 32'h4000_0000; wr = W2;
        dc = 0;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (done) dc++;
            if (c == 6) chk("g_c6_done", done, 1'b1);
            if (c == 8) chk("g_c8_htrans", ahb.HTRANS, 2'b00);
            if (c == 1 || c == 3 || c == 7) go = 1'b0;
            if (c == 2 || c == 6) go = 1'b1;
        end
        chk("g_done_count", 128'(dc), 128'(1));

        // ---- reset in cycle 3 of a write ----
        go = 1'b1; rw = 1'b1; addr = 32'h5000_0004; wr = W2;
        step(); // cycle 1
        go = 1'b0;
        step(); // cycle 2
        step(); // cycle 3
        #2;
        rst_n = 1'b0;
        #1;
        chk("x_htrans", ahb.HTRANS, 2'b00);
        chk("x_haddr",  ahb.HADDR, 32'h0);
        chk("x_hwdata", ahb.HWDATA, 32'h0);
        chk("x_hwrite", ahb.HWRITE, 1'b0);
        chk("x_hburst", ahb.HBURST, 3'b000);
        chk("x_done",   done, 1'b0);
        step();
        rst_n = 1'b1;
        go = 1'b1; rw = 1'b1; addr = 32'h6000_0000; wr = W1;
        step(); // cycle 1
        go = 1'b0;
        chk("x2_c1_htrans", ahb.HTRANS, 2'b10);
        chk("x2_c1_haddr",  ahb.HADDR, 32'h6000_0000);
        step(); // cycle 2
        chk("x2_c2_hwdata", ahb.HWDATA, 32'h1111_1111);
        step(); step(); step();
        step(); // cycle 6
        chk("x2_c6_done", done, 1'b1);
        chk("x2_c6_err",  err, 1'b0);
        step();

        // ---- go held high: back-to-back bursts ----
        go = 1'b1; rw = 1'b0; addr = 32'h7000_0020; ahb.HRDATA = 32'h0000_00C5;
        for (int c = 1; c <= 13; c++) begin
            step();
            chk($sformatf("b_c%0d_done", c), done, (c == 6 || c == 13));
            if (c == 7) chk("b_c7_htrans", ahb.HTRANS, 2'b00);
            if (c == 8) begin
                chk("b_c8_htrans", ahb.HTRANS, 2'b10);
                chk("b_c8_haddr",  ahb.HADDR, 32'h7000_0020);
            end
            if (c == 13) begin
                chk("b_c13_rddata", rd, 128'h000000C5_000000C5_000000C5_000000C5);
                go = 1'b0;
            end
        end
        step();
        chk("b_c14_done",   done, 1'b0);
        step();
        chk("b_c15_htrans", ahb.HTRANS, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
